// File: rtl/bram_dp_pkg.sv
// Shared types and constants for the dual-port local-memory block.
// Covers the clear/ready state encoding, the write-mode codes and the depth helpers.
package bram_dp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int depth_of(input int memsize, input int num_we);
    return memsize / num_we;
  endfunction

  // A depth of one still needs a one-bit index so the vectors stay legal.
  function automatic int idx_width_of(input int memsize, input int num_we);
    int w;
    w = clog2(depth_of(memsize, num_we));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bram_dp_port.sv
// One memory port: word-index decode, byte-lane merge, read-mode select and
// the one- or two-stage read-data register.
module bram_dp_port
  import bram_dp_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int NUM_WE  = 4,
  parameter int IDX_W   = 12,
  parameter int MODE    = WM_READ_FIRST,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic              en,
  input  logic [0:NUM_WE-1] wen,
  input  logic [0:AWIDTH-1] addr,
  input  logic [0:DWIDTH-1] wdata,
  input  logic [0:DWIDTH-1] rd_word,
  output logic [IDX_W-1:0]  idx,
  output logic [0:NUM_WE-1] wr_lanes,
  output logic              wr_en,
  output logic [0:DWIDTH-1] merged,
  output logic [0:DWIDTH-1] dout
);

  localparam int OFF = clog2(NUM_WE);

  logic              acc;
  logic [0:DWIDTH-1] rd_sel;
  logic [0:DWIDTH-1] rd_p1;

  assign acc      = ready & en;
  // Upper address bits simply fall off, so addresses wrap modulo the depth.
  assign idx      = IDX_W'(addr >> OFF);
  assign wr_lanes = acc ? wen : '0;
  assign wr_en    = |wr_lanes;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NUM_WE; i++) begin
      if (wen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // A port that only reads gets merged == rd_word, so a colliding reader
  // always sees the old word whatever its mode.
  assign rd_sel = (MODE == WM_WRITE_FIRST) ? merged : rd_word;

  // Stage p1: array output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1 <= '0;
    end else if (!ready) begin
      rd_p1 <= '0;
    end else if (en) begin
      rd_p1 <= rd_sel;
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic              vld_p1;
      logic [0:DWIDTH-1] rd_p2;

      // Stage p2: optional output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1 <= 1'b0;
          rd_p2  <= '0;
        end else if (!ready) begin
          vld_p1 <= 1'b0;
          rd_p2  <= '0;
        end else begin
          vld_p1 <= en;
          if (vld_p1) rd_p2 <= rd_p1;
        end
      end

      assign dout = rd_p2;
    end else begin : g_lat1
      assign dout = rd_p1;
    end
  endgenerate

endmodule

// File: rtl/bram_dp_block.sv
// True-dual-port local-memory block: shared array, post-reset zero-fill sweep,
// port-A-wins write arbitration and a sticky write/write collision flag.
module bram_dp_block
  import bram_dp_pkg::*;
#(
  parameter int    C_MEMSIZE        = 'h4000,
  parameter int    C_PORT_DWIDTH    = 32,
  parameter int    C_PORT_AWIDTH    = 32,
  parameter int    C_NUM_WE         = C_PORT_DWIDTH / 8,
  parameter int    C_READ_LATENCY   = 1,
  parameter string C_WRITE_MODE_A   = "READ_FIRST",
  parameter string C_WRITE_MODE_B   = "READ_FIRST",
  parameter int    C_CLEAR_ON_RESET = 1
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     BRAM_EN_A,
  input  logic [0:C_NUM_WE-1]      BRAM_WEN_A,
  input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Din_A,
  input  logic                     BRAM_EN_B,
  input  logic [0:C_NUM_WE-1]      BRAM_WEN_B,
  input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Din_B,
  output logic                     BRAM_Ready,
  output logic                     BRAM_Collision
);

  localparam int DEPTH  = depth_of(C_MEMSIZE, C_NUM_WE);
  localparam int IDX_W  = idx_width_of(C_MEMSIZE, C_NUM_WE);
  localparam int MODE_A = (C_WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST : WM_READ_FIRST;
  localparam int MODE_B = (C_WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST : WM_READ_FIRST;

  logic [0:C_PORT_DWIDTH-1] mem [DEPTH];

  state_e                   state;
  logic [IDX_W-1:0]         clr_cnt;
  logic                     ready_q;
  logic                     coll_q;

  logic [IDX_W-1:0]         idx_a, idx_b;
  logic [0:C_NUM_WE-1]      lanes_a, lanes_b;
  logic                     wr_a, wr_b;
  logic [0:C_PORT_DWIDTH-1] rd_a, rd_b;
  logic [0:C_PORT_DWIDTH-1] merged_a, merged_b;
  logic [0:C_PORT_DWIDTH-1] word_a;
  logic                     same_word;

  assign rd_a      = mem[idx_a];
  assign rd_b      = mem[idx_b];
  assign same_word = (idx_a == idx_b);

  bram_dp_port #(
    .DWIDTH (C_PORT_DWIDTH),
    .AWIDTH (C_PORT_AWIDTH),
    .NUM_WE (C_NUM_WE),
    .IDX_W  (IDX_W),
    .MODE   (MODE_A),
    .LATENCY(C_READ_LATENCY)
  ) u_port_a (
    .clk     (BRAM_Clk),
    .rst_n   (BRAM_Rst_N),
    .ready   (ready_q),
    .en      (BRAM_EN_A),
    .wen     (BRAM_WEN_A),
    .addr    (BRAM_Addr_A),
    .wdata   (BRAM_Dout_A),
    .rd_word (rd_a),
    .idx     (idx_a),
    .wr_lanes(lanes_a),
    .wr_en   (wr_a),
    .merged  (merged_a),
    .dout    (BRAM_Din_A)
  );

  bram_dp_port #(
    .DWIDTH (C_PORT_DWIDTH),
    .AWIDTH (C_PORT_AWIDTH),
    .NUM_WE (C_NUM_WE),
    .IDX_W  (IDX_W),
    .MODE   (MODE_B),
    .LATENCY(C_READ_LATENCY)
  ) u_port_b (
    .clk     (BRAM_Clk),
    .rst_n   (BRAM_Rst_N),
    .ready   (ready_q),
    .en      (BRAM_EN_B),
    .wen     (BRAM_WEN_B),
    .addr    (BRAM_Addr_B),
    .wdata   (BRAM_Dout_B),
    .rd_word (rd_b),
    .idx     (idx_b),
    .wr_lanes(lanes_b),
    .wr_en   (wr_b),
    .merged  (merged_b),
    .dout    (BRAM_Din_B)
  );

  // On a same-word write, fold B's lanes into A's word so one whole-word
  // write carries both; lanes written by both keep A's data.
  always_comb begin
    word_a = merged_a;
    if (same_word) begin
      for (int i = 0; i < C_NUM_WE; i++) begin
        if (lanes_b[i] && !lanes_a[i]) word_a[8*i +: 8] = BRAM_Dout_B[8*i +: 8];
      end
    end
  end

  // Stage p0: array update (sweep or port writes, A issued last so it wins)
  always_ff @(posedge BRAM_Clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr_b) mem[idx_b] <= merged_b;
      if (wr_a) mem[idx_a] <= word_a;
    end
  end

  // Ready trails the state by one edge, so traffic starts the edge after the last clear.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      state   <= (C_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
      ready_q <= (C_CLEAR_ON_RESET == 0);
      coll_q  <= 1'b0;
    end else begin
      ready_q <= (state == ST_READY);
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == IDX_W'(DEPTH - 1)) state <= ST_READY;
          else clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= ST_READY;
      endcase
      if (wr_a && wr_b && same_word) coll_q <= 1'b1;
    end
  end

  assign BRAM_Ready     = ready_q;
  assign BRAM_Collision = coll_q;

endmodule

// File: tb/tb_bram_dp_block.sv
// Bench for bram_dp_block: directed vector table plus randomized traffic
// against a word-array reference model, on a latency-1 and a latency-2 instance.
module tb_bram_dp_block;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [0:3]  wen_a, wen_b;
  logic [0:31] addr_a, addr_b, wd_a, wd_b;
  logic [0:31] din1_a, din1_b, din2_a, din2_b;
  logic        rdy1, rdy2, coll1, coll2;

  always #5 clk = ~clk;

  bram_dp_block #(
    .C_MEMSIZE('h40), .C_READ_LATENCY(1),
    .C_WRITE_MODE_A("WRITE_FIRST"), .C_WRITE_MODE_B("WRITE_FIRST"), .C_CLEAR_ON_RESET(1)
  ) dut1 (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(wd_a), .BRAM_Din_A(din1_a),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(wd_b), .BRAM_Din_B(din1_b),
    .BRAM_Ready(rdy1), .BRAM_Collision(coll1)
  );

  bram_dp_block #(
    .C_MEMSIZE('h40), .C_READ_LATENCY(2),
    .C_WRITE_MODE_A("READ_FIRST"), .C_WRITE_MODE_B("READ_FIRST"), .C_CLEAR_ON_RESET(1)
  ) dut2 (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(wd_a), .BRAM_Din_A(din2_a),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(wd_b), .BRAM_Din_B(din2_b),
    .BRAM_Ready(rdy2), .BRAM_Collision(coll2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain word array; dut1 = write-first/latency 1,
  // dut2 = read-first/latency 2.
  bit [0:31] m_mem [D];
  bit [0:31] m_a1, m_b1, m_ap1, m_bp1, m_a2, m_b2;
  bit        m_va, m_vb, m_ready, m_coll;
  int        m_e;

  function automatic int widx(input logic [0:31] a);
    return int'((a >> 2) % D);
  endfunction

  function automatic bit [0:31] merge(input bit [0:31] old, input bit [0:31] wd, input bit [0:3] wen);
    bit [0:31] r;
    r = old;
    for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_a1 = 0; m_b1 = 0; m_ap1 = 0; m_bp1 = 0; m_a2 = 0; m_b2 = 0;
    m_va = 0; m_vb = 0; m_ready = 0; m_coll = 0; m_e = 0;
  endtask

  task automatic model_edge();
    int ia, ib;
    bit [0:31] oa, ob;
    bit wa, wb;
    if (!m_ready) begin
      if (m_e < D) m_mem[m_e] = 0;
      m_e++;
      m_ready = (m_e > D);
      m_a1 = 0; m_b1 = 0; m_ap1 = 0; m_bp1 = 0; m_a2 = 0; m_b2 = 0;
      m_va = 0; m_vb = 0;
    end else begin
      ia = widx(addr_a); ib = widx(addr_b);
      oa = m_mem[ia];    ob = m_mem[ib];
      wa = en_a && (wen_a != 0);
      wb = en_b && (wen_b != 0);
      if (m_va) m_a2 = m_ap1;
      if (m_vb) m_b2 = m_bp1;
      m_va = en_a; m_vb = en_b;
      if (en_a) begin m_ap1 = oa; m_a1 = merge(oa, wd_a, wen_a); end
      if (en_b) begin m_bp1 = ob; m_b1 = merge(ob, wd_b, wen_b); end
      if (wa && wb && ia == ib) m_coll = 1;
      if (wb) m_mem[ib] = merge(m_mem[ib], wd_b, wen_b);
      if (wa) m_mem[ia] = merge(m_mem[ia], wd_a, wen_a);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("din1_a", din1_a, m_a1);
    check("din1_b", din1_b, m_b1);
    check("din2_a", din2_a, m_a2);
    check("din2_b", din2_b, m_b2);
    check("ready1", 32'(rdy1), 32'(m_ready));
    check("ready2", 32'(rdy2), 32'(m_ready));
    check("coll1", 32'(coll1), 32'(m_coll));
    check("coll2", 32'(coll2), 32'(m_coll));
  endtask

  task automatic drive(input bit ea, input bit [0:3] wa, input bit [31:0] aa, input bit [0:31] da,
                       input bit eb, input bit [0:3] wb, input bit [31:0] ab, input bit [0:31] db);
    en_a = ea; wen_a = wa; addr_a = aa; wd_a = da;
    en_b = eb; wen_b = wb; addr_b = ab; wd_b = db;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_din1_a"}, din1_a, 32'h0);
    check({tag, "_din1_b"}, din1_b, 32'h0);
    check({tag, "_din2_a"}, din2_a, 32'h0);
    check({tag, "_din2_b"}, din2_b, 32'h0);
    check({tag, "_ready"}, 32'(rdy1), 32'h0);
    check({tag, "_coll1"}, 32'(coll1), 32'h0);
    check({tag, "_coll2"}, 32'(coll2), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 1; k <= D + 1; k++) begin
      tick();
      check({tag, "_ready_edge"}, 32'(rdy1), (k == D + 1) ? 32'h1 : 32'h0);
    end
  endtask

  typedef struct {
    bit        en_a;  bit [0:3] wen_a; bit [31:0] ad_a; bit [0:31] wd_a;
    bit        en_b;  bit [0:3] wen_b; bit [31:0] ad_b; bit [0:31] wd_b;
    bit        ca, cb;
    bit [0:31] ea_wf, eb_wf, ea_rf, eb_rf;
    bit        ecoll;
  } vec_t;

  function automatic vec_t mk(input bit ea, input bit [0:3] wa, input bit [31:0] aa, input bit [0:31] da,
                              input bit eb, input bit [0:3] wb, input bit [31:0] ab, input bit [0:31] db,
                              input bit ca, input bit cb,
                              input bit [0:31] a_wf, input bit [0:31] b_wf,
                              input bit [0:31] a_rf, input bit [0:31] b_rf, input bit co);
    vec_t v;
    v.en_a = ea; v.wen_a = wa; v.ad_a = aa; v.wd_a = da;
    v.en_b = eb; v.wen_b = wb; v.ad_b = ab; v.wd_b = db;
    v.ca = ca; v.cb = cb;
    v.ea_wf = a_wf; v.eb_wf = b_wf; v.ea_rf = a_rf; v.eb_rf = b_rf; v.ecoll = co;
    return v;
  endfunction

  localparam int NV = 13;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    model_reset();

    //           enA wenA     addrA  dataA         enB wenB     addrB  dataB         ca cb  A_wf          B_wf          A_rf          B_rf          coll
    tbl[0]  = mk(1, 4'b0000, 'h3C, 32'h0,        0, 4'b0000, 'h0,  32'h0,        1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0);
    tbl[1]  = mk(1, 4'b1111, 'h10, 32'hDEADBEEF, 0, 4'b0000, 'h0,  32'h0,        1, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        0);
    tbl[2]  = mk(1, 4'b0100, 'h10, 32'h00AA0000, 0, 4'b0000, 'h0,  32'h0,        1, 0, 32'hDEAABEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0);
    tbl[3]  = mk(1, 4'b0000, 'h10, 32'h0,        0, 4'b0000, 'h0,  32'h0,        1, 0, 32'hDEAABEEF, 32'h0,        32'hDEAABEEF, 32'h0,        0);
    tbl[4]  = mk(1, 4'b1111, 'h08, 32'h22222222, 0, 4'b0000, 'h0,  32'h0,        1, 0, 32'h22222222, 32'h0,        32'h0,        32'h0,        0);
    tbl[5]  = mk(1, 4'b1100, 'h08, 32'h11111111, 1, 4'b0110, 'h08, 32'h22222222, 1, 1, 32'h11112222, 32'h22222222, 32'h22222222, 32'h22222222, 1);
    tbl[6]  = mk(1, 4'b0000, 'h08, 32'h0,        0, 4'b0000, 'h0,  32'h0,        1, 0, 32'h11112222, 32'h0,        32'h11112222, 32'h0,        1);
    tbl[7]  = mk(1, 4'b1111, 'h04, 32'h55555555, 1, 4'b0000, 'h04, 32'h0,        1, 1, 32'h55555555, 32'h0,        32'h0,        32'h0,        1);
    tbl[8]  = mk(1, 4'b0000, 'h04, 32'h0,        1, 4'b0000, 'h44, 32'h0,        1, 1, 32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555, 1);
    tbl[9]  = mk(1, 4'b0000, 'h3C, 32'h0,        1, 4'b1111, 'h7C, 32'hCAFEF00D, 1, 1, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0,        1);
    tbl[10] = mk(1, 4'b0000, 'h3C, 32'h0,        0, 4'b0000, 'h0,  32'h0,        1, 0, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        1);
    tbl[11] = mk(0, 4'b1111, 'h10, 32'hFFFFFFFF, 0, 4'b0000, 'h0,  32'h0,        1, 0, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        1);
    tbl[12] = mk(1, 4'b0000, 'h10, 32'h0,        0, 4'b0000, 'h0,  32'h0,        1, 0, 32'hDEAABEEF, 32'h0,        32'hDEAABEEF, 32'h0,        1);

    #3;
    check("rst_din1_a", din1_a, 32'h0);
    check("rst_din2_b", din2_b, 32'h0);
    check("rst_ready", 32'(rdy1), 32'h0);
    check("rst_coll", 32'(coll1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_check("sweep0");

    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(tbl[i].en_a, tbl[i].wen_a, tbl[i].ad_a, tbl[i].wd_a,
                        tbl[i].en_b, tbl[i].wen_b, tbl[i].ad_b, tbl[i].wd_b);
      else        drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
      tick();
      if (i < NV) begin
        if (tbl[i].ca) check($sformatf("vec%0d_lat1_a", i), din1_a, tbl[i].ea_wf);
        if (tbl[i].cb) check($sformatf("vec%0d_lat1_b", i), din1_b, tbl[i].eb_wf);
        check($sformatf("vec%0d_coll", i), 32'(coll1), 32'(tbl[i].ecoll));
      end
      if (i > 0) begin
        if (tbl[i-1].ca) check($sformatf("vec%0d_lat2_a", i - 1), din2_a, tbl[i-1].ea_rf);
        if (tbl[i-1].cb) check($sformatf("vec%0d_lat2_b", i - 1), din2_b, tbl[i-1].eb_rf);
      end
    end

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000,
            32'($urandom_range(0, 'hFF)), $urandom,
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000,
            32'($urandom_range(0, 'hFF)), $urandom);
      tick();
    end

    apply_reset("rst_traffic");
    for (int k = 0; k < 7; k++) tick();
    apply_reset("rst_sweep7");
    sweep_check("sweep1");

    drive(1, 4'b0000, 'h3C, 0, 1, 4'b0000, 'h20, 0);
    tick();
    check("post_sweep_a", din1_a, 32'h0);
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    tick();
    check("post_sweep_lat2_a", din2_a, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_dp_block.md
# bram_dp_block

Parametrised true-dual-port block RAM for the MicroBlaze local-memory path: two independent LMB-side ports (A, B) on one clock, byte-lane writes, configurable width, depth and read latency. It adds deterministic same-address collision resolution, a sticky collision flag and a post-reset clear sweep that zero-fills the array before accepting traffic. It sits between the two LMB BRAM interface controllers (instruction and data) and replaces the fixed 32-bit, 16 KiB single-latency memory block.

## Interface
- C_MEMSIZE, 'h4000, size in bytes; C_MEMSIZE/C_NUM_WE must be a power of two
- C_PORT_DWIDTH, 32, data width; multiple of 8 (8..64)
- C_PORT_AWIDTH, 32, byte-address width
- C_NUM_WE, C_PORT_DWIDTH/8, byte enables per port (derived, not overridden)
- C_READ_LATENCY, 1, 1 = array output only, 2 = extra output register
- C_WRITE_MODE_A / C_WRITE_MODE_B, "READ_FIRST", "READ_FIRST" or "WRITE_FIRST" per port
- C_CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset, 0 = ready immediately
- BRAM_Clk  in  1  single clock for both ports
- BRAM_Rst_N  in  1  asynchronous, active-low reset
- BRAM_EN_A / BRAM_EN_B  in  1  port enable
- BRAM_WEN_A / BRAM_WEN_B  in  [0:C_NUM_WE-1]  byte write enables; bit 0 = bits [0:7]
- BRAM_Addr_A / BRAM_Addr_B  in  [0:C_PORT_AWIDTH-1]  byte address
- BRAM_Dout_A / BRAM_Dout_B  in  [0:C_PORT_DWIDTH-1]  write data (controller's Dout)
- BRAM_Din_A / BRAM_Din_B  out  [0:C_PORT_DWIDTH-1]  read data (controller's Din)
- BRAM_Ready  out  1  high when sweep done; accesses honoured only when high
- BRAM_Collision  out  1  sticky: set on any same-word write/write collision

## Operation
- Depth D = C_MEMSIZE/C_NUM_WE; word index = byte address >> log2(C_NUM_WE), modulo D (high bits ignored, wrap-around).
- Write: EN=1 and WEN lane bit=1 updates that byte only; other lanes keep old data.
- Read data: every EN=1 access returns the word; READ_FIRST returns pre-write contents, WRITE_FIRST returns merged new word.
- EN=0: Din holds last value.
- Collision, same word, both writing: lane written by both -> port A data wins; BRAM_Collision sets until reset.
- Collision, one writes, other reads same word: reader sees old word (reader is READ_FIRST regardless of its mode); no flag.
- FSM states: CLEAR, READY. Reset -> CLEAR if C_CLEAR_ON_RESET else READY. CLEAR writes zero to word counter 0..D-1, one per cycle; at D-1 -> READY. READY terminal until reset.
- In CLEAR: port writes dropped, Din outputs forced 0, BRAM_Ready=0.
- Reset mid-sweep or mid-access: FSM, counter, output registers and flag clear immediately; sweep restarts at word 0; array contents otherwise undefined.

## Timing
- Reset values: BRAM_Din_A/B = 0, BRAM_Ready = 0 (1 if C_CLEAR_ON_RESET=0), BRAM_Collision = 0.
- First cycle after reset release with clear enabled: sweep writes word 0; BRAM_Ready rises on the edge after word D-1 is written (D+1 edges after release).
- Read latency: Din valid C_READ_LATENCY rising edges after edge sampling EN=1.
- Write takes effect at sampling edge; read of same word on next cycle returns new data.
- Pipelined accesses: one per port per cycle, no stalls.

## Structure
- Package bram_dp_pkg: state enum (ST_CLEAR, ST_READY), write-mode constants, clog2 function, derived depth/index-width constants.
- Sub-module bram_dp_port: one port's address decode, byte-merge, read-mode mux and optional output register; instantiated twice. Top holds array, FSM, sweep counter and collision arbitration.

## Test plan
- Reset, C_CLEAR_ON_RESET=1, C_MEMSIZE='h40 (D=16) -> BRAM_Ready low 17 edges; then read addr 'h3C returns 0.
- Port A write 'hDEADBEEF at 'h10, WEN=4'b1111; then WEN=4'b0100 data 'h00AA0000 -> read 'hDEAABEEF at latency 1 and 2.
- Both ports write addr 'h08: A='h11111111 WEN=1100, B='h22222222 WEN=0110 -> word 'h11112222 (lane 2 from B, lane 1 from A), BRAM_Collision=1 until reset.
- A writes 'h55 pattern to 'h04 while B reads 'h04, B mode WRITE_FIRST -> B gets old word; A (WRITE_FIRST) gets 'h55555555.
- Address 'h44 with D=16 -> aliases word 1 (same as 'h04).
- Assert BRAM_Rst_N low at sweep word 7 -> outputs 0 at once; after release sweep restarts at 0, Ready after 17 edges.
